// File: rtl/minrv32_dmem.sv
// Data-memory responder for the minrv32 memory port: shifts right-justified lanes to the
// byte offset, splits word-crossing accesses over two RAM cycles, adds wait states and errors.
module minrv32_dmem #(
  parameter int          ADDR_WIDTH     = 10,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          WAIT_STATES    = 0,
  parameter bit          ALLOW_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic [3:0]  mem_rmask,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);
  localparam int          DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  WS_LAST = 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WAIT = 3'd1, S_ACC0 = 3'd2, S_ACC1 = 3'd3, S_DONE = 3'd4, S_ERR = 3'd5
  } state_t;

  function automatic logic [2:0] mask_bytes(input logic [3:0] m);
    case (m)
      4'b0001: mask_bytes = 3'd1;
      4'b0011: mask_bytes = 3'd2;
      4'b1111: mask_bytes = 3'd4;
      default: mask_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] assemble(input logic [31:0] hi, input logic [31:0] lo,
                                           input logic [1:0] off, input logic [3:0] m);
    logic [63:0] sh;
    sh = {hi, lo} >> {off, 3'b000};
    assemble = sh[31:0] & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  state_t                r_state;
  logic [3:0]            r_wait_cnt;
  logic [ADDR_WIDTH-1:0] r_word;
  logic [1:0]            r_off;
  logic [3:0]            r_mask;
  logic [31:0]           r_wdata;
  logic                  r_is_wr;
  logic                  r_split;
  logic [31:0]           r_lo;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_is_wr;
  logic [3:0]            w_mask;
  logic [2:0]            w_n;
  logic [1:0]            w_off;
  logic [31:0]           w_rel;
  logic [31:0]           w_word;
  logic                  w_split;
  logic                  w_bad;
  logic [7:0]            w_be64;
  logic [63:0]           w_wd64;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [3:0]            w_be;
  logic [31:0]           w_wd;
  logic                  w_we;
  logic [31:0]           w_rd_word;
  logic                  w_unused;

  // Classify the incoming request; the last-word check stops a split from wrapping to word 0.
  always_comb begin
    w_is_wr = (mem_wstrb != 4'b0000);
    w_mask  = w_is_wr ? mem_wstrb : mem_rmask;
    w_n     = mask_bytes(w_mask);
    w_off   = mem_addr[1:0];
    w_rel   = mem_addr - BASE_ADDR;
    w_word  = {2'b00, w_rel[31:2]};
    w_split = ({1'b0, w_off} + w_n) > 3'd4;
    w_bad   = (w_n == 3'd0) || (mem_addr < BASE_ADDR) || (w_word >= DEPTH_W) ||
              (w_split && (w_word == DEPTH_W - 32'd1)) || (w_split && !ALLOW_MISALIGN);
  end

  // Lane placement: the low half of the shifted mask/data targets word w, the high half w+1.
  always_comb begin
    w_be64 = {4'b0000, r_mask} << r_off;
    w_wd64 = {32'd0, r_wdata} << {r_off, 3'b000};
    if (r_state == S_ACC1) begin
      w_ram_addr = r_word + ADDR_WIDTH'(1);
      w_be       = w_be64[7:4];
      w_wd       = w_wd64[63:32];
    end else begin
      w_ram_addr = r_word;
      w_be       = w_be64[3:0];
      w_wd       = w_wd64[31:0];
    end
    w_we = r_is_wr && ((r_state == S_ACC0) || (r_state == S_ACC1));
  end

  assign w_rd_word = r_mem[w_ram_addr];
  assign w_unused  = ^{mem_instr, w_rel[1:0]};

  // Byte-lane RAM write; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_ram_addr][8*b +: 8] <= w_wd[8*b +: 8];
      end
    end
  end

  // Request sequencer with registered completion outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_word     <= {ADDR_WIDTH{1'b0}};
      r_off      <= 2'd0;
      r_mask     <= 4'd0;
      r_wdata    <= 32'd0;
      r_is_wr    <= 1'b0;
      r_split    <= 1'b0;
      r_lo       <= 32'd0;
      mem_ready  <= 1'b0;
      mem_rdata  <= 32'd0;
      mem_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_valid) begin
            r_word  <= w_word[ADDR_WIDTH-1:0];
            r_off   <= w_off;
            r_mask  <= w_mask;
            r_wdata <= mem_wdata;
            r_is_wr <= w_is_wr;
            r_split <= w_split;
            if (w_bad) begin
              r_state   <= S_ERR;
              mem_ready <= 1'b1;
              mem_err   <= 1'b1;
              mem_rdata <= 32'd0;
            end else if (WAIT_STATES > 0) begin
              r_state    <= S_WAIT;
              r_wait_cnt <= 4'd0;
            end else begin
              r_state <= S_ACC0;
            end
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == WS_LAST) begin
            r_wait_cnt <= 4'd0;
            r_state    <= S_ACC0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        S_ACC0: begin
          r_lo <= w_rd_word;
          if (r_split) begin
            r_state <= S_ACC1;
          end else begin
            r_state   <= S_DONE;
            mem_ready <= 1'b1;
            mem_rdata <= r_is_wr ? 32'd0 : assemble(32'd0, w_rd_word, r_off, r_mask);
          end
        end
        S_ACC1: begin
          r_state   <= S_DONE;
          mem_ready <= 1'b1;
          mem_rdata <= r_is_wr ? 32'd0 : assemble(w_rd_word, r_lo, r_off, r_mask);
        end
        S_DONE, S_ERR: begin
          r_state   <= S_IDLE;
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          mem_rdata <= 32'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_minrv32_dmem.sv
// Directed bench for minrv32_dmem: dut1 has no wait states, dut2 has two.
module tb_minrv32_dmem;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m1_valid = 1'b0, m1_instr = 1'b0;
  logic [31:0] m1_addr = 32'd0, m1_wdata = 32'd0;
  logic [3:0] m1_wstrb = 4'd0, m1_rmask = 4'd0;
  logic m1_ready, m1_err;
  logic [31:0] m1_rdata;
  logic m2_valid = 1'b0, m2_instr = 1'b0;
  logic [31:0] m2_addr = 32'd0, m2_wdata = 32'd0;
  logic [3:0] m2_wstrb = 4'd0, m2_rmask = 4'd0;
  logic m2_ready, m2_err;
  logic [31:0] m2_rdata;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  minrv32_dmem dut1 (
    .clk(clk), .reset(reset), .mem_valid(m1_valid), .mem_instr(m1_instr), .mem_addr(m1_addr),
    .mem_wdata(m1_wdata), .mem_wstrb(m1_wstrb), .mem_rmask(m1_rmask),
    .mem_ready(m1_ready), .mem_rdata(m1_rdata), .mem_err(m1_err)
  );

  minrv32_dmem #(.WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset), .mem_valid(m2_valid), .mem_instr(m2_instr), .mem_addr(m2_addr),
    .mem_wdata(m2_wdata), .mem_wstrb(m2_wstrb), .mem_rmask(m2_rmask),
    .mem_ready(m2_ready), .mem_rdata(m2_rdata), .mem_err(m2_err)
  );

  // Issue one request at a negedge; report the cycle of mem_ready (-1 if it never came).
  task automatic do_req(input bit sel, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [3:0] rm,
                        output int lat, output logic [31:0] rd, output logic er);
    lat = -1;
    rd = 32'd0;
    er = 1'b0;
    @(negedge clk);
    if (sel) begin
      m2_valid = 1'b1; m2_addr = a; m2_wdata = wd; m2_wstrb = ws; m2_rmask = rm;
    end else begin
      m1_valid = 1'b1; m1_addr = a; m1_wdata = wd; m1_wstrb = ws; m1_rmask = rm;
    end
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      m1_valid = 1'b0;
      m2_valid = 1'b0;
      if (sel ? m2_ready : m1_ready) begin
        lat = c;
        rd = sel ? m2_rdata : m1_rdata;
        er = sel ? m2_err : m1_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (m1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", m1_ready); end
    checks++; if (m1_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", m1_rdata); end
    checks++; if (m1_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", m1_err); end
    checks++; if (m2_ready !== 1'b0) begin errors++; $display("FAIL reset_ready2: got %b expected 0", m2_ready); end
  endtask

  task automatic test_aligned();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b0, 32'h100, 32'hDEADBEEF, 4'b1111, 4'b0000, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_err: got %b expected 0", er); end
    do_req(1'b0, 32'h100, 32'h0, 4'b0000, 4'b1111, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", er); end
    @(negedge clk);
    checks++; if (m1_rdata !== 32'd0) begin errors++; $display("FAIL rdata_after_ready: got %h expected 0", m1_rdata); end
  endtask

  task automatic test_subword();
    int lat; logic [31:0] rd; logic er;
    m1_instr = 1'b1;
    do_req(1'b0, 32'h103, 32'h000000AA, 4'b0001, 4'b0000, lat, rd, er);
    do_req(1'b0, 32'h100, 32'h0, 4'b0000, 4'b1111, lat, rd, er);
    checks++; if (rd !== 32'hAAADBEEF) begin errors++; $display("FAIL sb_then_lw: got %h expected aaadbeef", rd); end
    do_req(1'b0, 32'h103, 32'h0, 4'b0000, 4'b0001, lat, rd, er);
    checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL lb_103: got %h expected 000000aa", rd); end
    do_req(1'b0, 32'h102, 32'h0, 4'b0000, 4'b0011, lat, rd, er);
    checks++; if (rd !== 32'h0000AAAD) begin errors++; $display("FAIL lhu_102: got %h expected 0000aaad", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lhu_latency: got %0d expected 2", lat); end
    m1_instr = 1'b0;
  endtask

  task automatic test_split();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b0, 32'h104, 32'h0, 4'b1111, 4'b0000, lat, rd, er);
    do_req(1'b0, 32'h108, 32'h0, 4'b1111, 4'b0000, lat, rd, er);
    do_req(1'b0, 32'h106, 32'h11223344, 4'b1111, 4'b0000, lat, rd, er);
    checks++; if (lat !== 3) begin errors++; $display("FAIL split_sw_latency: got %0d expected 3", lat); end
    do_req(1'b0, 32'h104, 32'h0, 4'b0000, 4'b1111, lat, rd, er);
    checks++; if (rd !== 32'h33440000) begin errors++; $display("FAIL split_low_word: got %h expected 33440000", rd); end
    do_req(1'b0, 32'h108, 32'h0, 4'b0000, 4'b1111, lat, rd, er);
    checks++; if (rd !== 32'h00001122) begin errors++; $display("FAIL split_high_word: got %h expected 00001122", rd); end
    do_req(1'b0, 32'h106, 32'h0, 4'b0000, 4'b1111, lat, rd, er);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL split_lw: got %h expected 11223344", rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL split_lw_latency: got %0d expected 3", lat); end
    do_req(1'b0, 32'h107, 32'h0, 4'b0000, 4'b0011, lat, rd, er);
    checks++; if (rd !== 32'h00002233) begin errors++; $display("FAIL split_lh_107: got %h expected 00002233", rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL split_lh_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_wait_states();
    int lat; logic [31:0] rd; logic er;
    int r1, r2, pulses;
    logic [31:0] d1;
    do_req(1'b1, 32'h200, 32'h0BADCAFE, 4'b1111, 4'b0000, lat, rd, er);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ws_sw_latency: got %0d expected 4", lat); end
    do_req(1'b1, 32'h200, 32'h0, 4'b0000, 4'b1111, lat, rd, er);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ws_lw_latency: got %0d expected 4", lat); end
    checks++; if (rd !== 32'h0BADCAFE) begin errors++; $display("FAIL ws_lw_data: got %h expected 0badcafe", rd); end
    do_req(1'b1, 32'h202, 32'h12345678, 4'b1111, 4'b0000, lat, rd, er);
    do_req(1'b1, 32'h202, 32'h0, 4'b0000, 4'b1111, lat, rd, er);
    checks++; if (lat !== 5) begin errors++; $display("FAIL ws_split_latency: got %0d expected 5", lat); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL ws_split_data: got %h expected 12345678", rd); end
    r1 = -1; r2 = -1; pulses = 0; d1 = 32'd0;
    @(negedge clk);
    m2_valid = 1'b1; m2_addr = 32'h200; m2_wstrb = 4'b0000; m2_rmask = 4'b1111;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 10) m2_valid = 1'b0;
      if (m2_ready) begin
        pulses++;
        if (r1 < 0) begin r1 = c; d1 = m2_rdata; end
        else if (r2 < 0) r2 = c;
      end
    end
    checks++; if (r1 !== 4) begin errors++; $display("FAIL b2b_first_ready: got %0d expected 4", r1); end
    checks++; if (r2 !== 9) begin errors++; $display("FAIL b2b_second_ready: got %0d expected 9", r2); end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulse_count: got %0d expected 2", pulses); end
    checks++; if (d1 !== 32'h5678CAFE) begin errors++; $display("FAIL b2b_data: got %h expected 5678cafe", d1); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b0, 32'h000, 32'hA5A5A5A5, 4'b1111, 4'b0000, lat, rd, er);
    do_req(1'b0, 32'hFFC, 32'h5A5A5A5A, 4'b1111, 4'b0000, lat, rd, er);
    do_req(1'b0, 32'h1000, 32'h0, 4'b0000, 4'b1111, lat, rd, er);
    checks++; if (lat !== 1) begin errors++; $display("FAIL err_oob_latency: got %0d expected 1", lat); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_oob_flag: got %b expected 1", er); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL err_oob_rdata: got %h expected 0", rd); end
    do_req(1'b0, 32'h000, 32'h0, 4'b0000, 4'b0101, lat, rd, er);
    checks++; if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL err_rmask: got err=%b lat=%0d expected err=1 lat=1", er, lat); end
    do_req(1'b0, 32'hFFE, 32'hFFFFFFFF, 4'b1111, 4'b0000, lat, rd, er);
    checks++; if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL err_split_last: got err=%b lat=%0d expected err=1 lat=1", er, lat); end
    do_req(1'b0, 32'h1000, 32'hFFFFFFFF, 4'b1111, 4'b0000, lat, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_oob_write: got %b expected 1", er); end
    do_req(1'b0, 32'h000, 32'hFFFFFFFF, 4'b0101, 4'b0000, lat, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_wstrb: got %b expected 1", er); end
    do_req(1'b0, 32'h000, 32'h0, 4'b0000, 4'b1111, lat, rd, er);
    checks++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin errors++; $display("FAIL err_word0_kept: got %h err=%b expected a5a5a5a5 err=0", rd, er); end
    do_req(1'b0, 32'hFFC, 32'h0, 4'b0000, 4'b1111, lat, rd, er);
    checks++; if (rd !== 32'h5A5A5A5A || er !== 1'b0) begin errors++; $display("FAIL err_last_kept: got %h err=%b expected 5a5a5a5a err=0", rd, er); end
  endtask

  task automatic test_reset_mid_split();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b0, 32'h10C, 32'h01020304, 4'b1111, 4'b0000, lat, rd, er);
    do_req(1'b0, 32'h110, 32'h55667788, 4'b1111, 4'b0000, lat, rd, er);
    @(negedge clk);
    m1_valid = 1'b1; m1_addr = 32'h10E; m1_wdata = 32'hCAFEF00D; m1_wstrb = 4'b1111; m1_rmask = 4'b0000;
    @(negedge clk);
    m1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (m1_ready !== 1'b0 || m1_err !== 1'b0 || m1_rdata !== 32'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got ready=%b err=%b rdata=%h expected all 0", m1_ready, m1_err, m1_rdata);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_req(1'b0, 32'h100, 32'h0, 4'b0000, 4'b1111, lat, rd, er);
    checks++; if (lat !== 2 || rd !== 32'hAAADBEEF) begin errors++; $display("FAIL post_reset_lw: got lat=%0d data=%h expected lat=2 data=aaadbeef", lat, rd); end
    do_req(1'b0, 32'h10C, 32'h0, 4'b0000, 4'b1111, lat, rd, er);
    checks++; if (rd !== 32'hF00D0304) begin errors++; $display("FAIL mid_reset_word_w: got %h expected f00d0304", rd); end
    do_req(1'b0, 32'h110, 32'h0, 4'b0000, 4'b1111, lat, rd, er);
    checks++; if (rd !== 32'h55667788) begin errors++; $display("FAIL mid_reset_word_w1: got %h expected 55667788", rd); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_aligned();
    test_subword();
    test_split();
    test_wait_states();
    test_errors();
    test_reset_mid_split();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
